// File: rtl/x_stack_pkg.sv
// Shared definitions for the x_stack execution-aware access monitor:
// FSM encoding, violation-cause bit positions and the default release PC.
package x_stack_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      KILL = 1'b1
   } state_e;

   localparam int CAUSE_V1 = 0;
   localparam int CAUSE_V2 = 1;
   localparam int CAUSE_V3 = 2;

   localparam logic [15:0] DEF_RESET_HANDLER = 16'hFFFE;

endpackage

// File: rtl/x_range_chk.sv
// Inclusive address window test [base, base+size-1], done in 17 bits so a
// window touching the top of the 16-bit map cannot wrap around to zero.
module x_range_chk (
   input  logic [15:0] addr,
   input  logic [15:0] base,
   input  logic [15:0] size,
   output logic        hit
);

   logic [16:0] addr_s;
   logic [16:0] lo_s;
   logic [16:0] end_s;

   assign addr_s = {1'b0, addr};
   assign lo_s   = {1'b0, base};
   // end_s is one past the last byte, so size==0 gives an empty window
   assign end_s  = {1'b0, base} + {1'b0, size};
   assign hit    = (addr_s >= lo_s) && (addr_s < end_s);

endmodule

// File: rtl/x_stack_mc.sv
// Multi-channel access monitor: checks CPU and DMA traffic against protected
// regions, the trusted code region and the HMAC window; holds reset on abuse.
module x_stack_mc
   import x_stack_pkg::*;
#(
   parameter int                 NREG          = 2,
   parameter logic [16*NREG-1:0] REG_BASE      = {16'h0400, 16'hA000},
   parameter logic [16*NREG-1:0] REG_SIZE      = {16'h0100, 16'h1000},
   parameter logic [15:0]        SMEM_BASE     = 16'hE000,
   parameter logic [15:0]        SMEM_SIZE     = 16'h1000,
   parameter logic [15:0]        HMAC_BASE     = 16'h8000,
   parameter logic [15:0]        HMAC_SIZE     = 16'h001F,
   parameter logic [15:0]        RESET_HANDLER = DEF_RESET_HANDLER,
   parameter int                 HOLD_CYCLES   = 4,
   parameter int                 CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [15:0]      pc,
   input  logic [15:0]      data_addr,
   input  logic             r_en,
   input  logic             w_en,
   input  logic [15:0]      dma_addr,
   input  logic             dma_en,
   output logic             reset,
   output logic [2:0]       viol_cause,
   output logic [CNT_W-1:0] viol_cnt,
   output logic             state_kill
);

   // The counter spans the whole KILL dwell: HOLD_CYCLES held KILL cycles
   // precede the earliest release cycle, giving HOLD_CYCLES+1 reset cycles.
   localparam int          HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

   logic [NREG-1:0] cpu_hit_s;
   logic [NREG-1:0] dma_hit_s;
   logic            pc_srom_s, cpu_hmac_s, dma_hmac_s, in_reg_s, dma_reg_s;
   logic            v1_s, v2_s, v3_s, viol_s, exit_s, reset_s;

   state_e          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [2:0]      cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   for (genvar g = 0; g < NREG; g++) begin : g_reg
      x_range_chk u_cpu (.addr(data_addr), .base(REG_BASE[16*g +: 16]),
                         .size(REG_SIZE[16*g +: 16]), .hit(cpu_hit_s[g]));
      x_range_chk u_dma (.addr(dma_addr), .base(REG_BASE[16*g +: 16]),
                         .size(REG_SIZE[16*g +: 16]), .hit(dma_hit_s[g]));
   end

   // Last SROM byte is excluded from the trusted PC range
   x_range_chk u_srom (.addr(pc), .base(SMEM_BASE), .size(SMEM_SIZE - 16'd1), .hit(pc_srom_s));
   x_range_chk u_hcpu (.addr(data_addr), .base(HMAC_BASE), .size(HMAC_SIZE), .hit(cpu_hmac_s));
   x_range_chk u_hdma (.addr(dma_addr), .base(HMAC_BASE), .size(HMAC_SIZE), .hit(dma_hmac_s));

   assign in_reg_s  = |cpu_hit_s;
   assign dma_reg_s = |dma_hit_s;
   assign v1_s      = !pc_srom_s && in_reg_s && (r_en || w_en);
   assign v2_s      = pc_srom_s && w_en && !in_reg_s && !cpu_hmac_s;
   assign v3_s      = dma_en && (dma_reg_s || dma_hmac_s);
   assign viol_s    = v1_s || v2_s || v3_s;
   assign exit_s    = (hold_q == {HW{1'b0}}) && (pc == RESET_HANDLER) && !viol_s;

   // Next-state, hold counter, cause/count capture and reset request
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      reset_s = 1'b0;
      case (state_q)
         RUN: begin
            if (viol_s) begin
               state_d           = KILL;
               hold_d            = HOLD_LOAD;
               cause_d[CAUSE_V1] = v1_s;
               cause_d[CAUSE_V2] = v2_s;
               cause_d[CAUSE_V3] = v3_s;
               cnt_d             = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
               reset_s           = 1'b1;
            end else begin
               state_d = RUN;
               reset_s = 1'b0;
            end
         end
         KILL: begin
            if (exit_s) begin
               state_d = RUN;
               reset_s = 1'b0;
            end else begin
               reset_s = 1'b1;
               if (hold_q != {HW{1'b0}}) begin
                  hold_d = hold_q - HW'(1);
               end else begin
                  hold_d = hold_q;
               end
            end
         end
         default: begin
            state_d = RUN;
            hold_d  = {HW{1'b0}};
         end
      endcase
   end

   // State, hold counter and violation record registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         hold_q  <= {HW{1'b0}};
         cause_q <= 3'b000;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   assign reset      = reset_n && reset_s;
   assign viol_cause = cause_q;
   assign viol_cnt   = cnt_q;
   assign state_kill = (state_q == KILL);

endmodule

// File: tb/tb_x_stack_mc.sv
// Directed bench for x_stack_mc: table of per-cycle vectors plus hand-written
// kill/release, saturation and asynchronous-reset sequences.
module tb_x_stack_mc;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] pc, data_addr, dma_addr;
   logic        r_en, w_en, dma_en;
   logic        reset, state_kill, reset2, state_kill2;
   logic [2:0]  viol_cause, viol_cause2;
   logic [7:0]  viol_cnt;
   logic [1:0]  viol_cnt2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] da;
      logic        r;
      logic        w;
      logic [15:0] dma_a;
      logic        dma_e;
      logic        e_reset;
      logic        e_kill;
      logic [2:0]  e_cause;
      logic [7:0]  e_cnt;
   } vec_t;

   localparam int NV = 24;
   vec_t tv[NV];

   x_stack_mc u_dut (
      .clk(clk), .reset_n(reset_n), .pc(pc), .data_addr(data_addr), .r_en(r_en),
      .w_en(w_en), .dma_addr(dma_addr), .dma_en(dma_en), .reset(reset),
      .viol_cause(viol_cause), .viol_cnt(viol_cnt), .state_kill(state_kill)
   );

   x_stack_mc #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .pc(pc), .data_addr(data_addr), .r_en(r_en),
      .w_en(w_en), .dma_addr(dma_addr), .dma_en(dma_en), .reset(reset2),
      .viol_cause(viol_cause2), .viol_cnt(viol_cnt2), .state_kill(state_kill2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] p, input logic [15:0] d, input logic r,
                        input logic w, input logic [15:0] da, input logic de);
      pc = p; data_addr = d; r_en = r; w_en = w; dma_addr = da; dma_en = de;
   endtask

   // One violation followed by release at the handler; counts reset cycles
   task automatic kill_release(input string name, input logic [15:0] p, input logic [15:0] d,
                               input logic r, input logic w, input logic [15:0] da,
                               input logic de, input logic [2:0] e_cause,
                               input logic [7:0] e_cnt);
      int n;
      drive(p, d, r, w, da, de);
      #3;
      chk({name, " viol_reset"}, 16'(reset), 16'd1);
      cyc();
      drive(16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0);
      #3;
      n = 0;
      while (reset === 1'b1 && n < 12) begin
         n++;
         cyc();
         #3;
      end
      chk({name, " kill_dwell"}, 16'(n), 16'd4);
      chk({name, " cause"}, 16'(viol_cause), 16'(e_cause));
      chk({name, " cnt"}, 16'(viol_cnt), 16'(e_cnt));
      chk({name, " cnt_sat"}, 16'(viol_cnt2), 16'(2'b11));
      cyc();
      drive(16'h4000, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   initial begin
      tv[0]  = '{16'h4000, 16'h9000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0};
      tv[1]  = '{16'h4000, 16'h0450, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 8'd0};
      tv[2]  = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b001, 8'd1};
      tv[3]  = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b001, 8'd1};
      tv[4]  = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b001, 8'd1};
      tv[5]  = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b001, 8'd1};
      tv[6]  = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1};
      tv[7]  = '{16'h4000, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b001, 8'd1};
      tv[8]  = '{16'hE100, 16'h2000, 1'b0, 1'b1, 16'h8004, 1'b1, 1'b1, 1'b0, 3'b001, 8'd1};
      tv[9]  = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b110, 8'd2};
      tv[10] = '{16'hFFFE, 16'h0450, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b110, 8'd2};
      tv[11] = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b110, 8'd2};
      tv[12] = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b110, 8'd2};
      tv[13] = '{16'h4000, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b110, 8'd2};
      tv[14] = '{16'hFFFE, 16'hA010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b110, 8'd2};
      tv[15] = '{16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'b110, 8'd2};
      tv[16] = '{16'h4000, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b110, 8'd2};
      tv[17] = '{16'h4000, 16'h0500, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b110, 8'd2};
      tv[18] = '{16'h4000, 16'h03FF, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b110, 8'd2};
      tv[19] = '{16'hEFFE, 16'h801E, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b110, 8'd2};
      tv[20] = '{16'hEFFF, 16'h2000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b110, 8'd2};
      tv[21] = '{16'h4000, 16'h9000, 1'b0, 1'b0, 16'h801F, 1'b1, 1'b0, 1'b0, 3'b110, 8'd2};
      tv[22] = '{16'h4000, 16'h9000, 1'b0, 1'b0, 16'hB000, 1'b1, 1'b0, 1'b0, 3'b110, 8'd2};
      tv[23] = '{16'hE000, 16'hA000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b110, 8'd2};

      // Reset held low with a violating access present
      reset_n = 1'b0;
      drive(16'h4000, 16'h0450, 1'b0, 1'b1, 16'h0000, 1'b0);
      #2;
      chk("rst reset", 16'(reset), 16'd0);
      chk("rst kill", 16'(state_kill), 16'd0);
      chk("rst cause", 16'(viol_cause), 16'd0);
      chk("rst cnt", 16'(viol_cnt), 16'd0);
      @(posedge clk);
      #3;
      drive(16'h4000, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0);
      reset_n = 1'b1;
      cyc();

      for (int i = 0; i < NV; i++) begin
         drive(tv[i].pc, tv[i].da, tv[i].r, tv[i].w, tv[i].dma_a, tv[i].dma_e);
         #3;
         chk($sformatf("row%0d reset", i), 16'(reset), 16'(tv[i].e_reset));
         chk($sformatf("row%0d kill", i), 16'(state_kill), 16'(tv[i].e_kill));
         chk($sformatf("row%0d cause", i), 16'(viol_cause), 16'(tv[i].e_cause));
         chk($sformatf("row%0d cnt", i), 16'(viol_cnt), 16'(tv[i].e_cnt));
         cyc();
      end

      // Five more entries: wide counter keeps counting, 2-bit one saturates
      kill_release("sat1", 16'h4000, 16'h9000, 1'b0, 1'b0, 16'hAFFF, 1'b1, 3'b100, 8'd3);
      kill_release("sat2", 16'hEFFE, 16'h801F, 1'b0, 1'b1, 16'h0000, 1'b0, 3'b010, 8'd4);
      kill_release("sat3", 16'h4000, 16'h04FF, 1'b1, 1'b0, 16'h0000, 1'b0, 3'b001, 8'd5);
      kill_release("sat4", 16'h4000, 16'h9000, 1'b0, 1'b0, 16'h0400, 1'b1, 3'b100, 8'd6);
      kill_release("sat5", 16'h4000, 16'hA000, 1'b0, 1'b1, 16'h801E, 1'b1, 3'b101, 8'd7);

      // Asynchronous reset while in KILL
      drive(16'h4000, 16'h0450, 1'b0, 1'b1, 16'h0000, 1'b0);
      cyc();
      drive(16'hFFFE, 16'h9000, 1'b0, 1'b0, 16'h0000, 1'b0);
      #3;
      chk("async pre kill", 16'(state_kill), 16'd1);
      chk("async pre reset", 16'(reset), 16'd1);
      reset_n = 1'b0;
      #1;
      chk("async reset", 16'(reset), 16'd0);
      chk("async kill", 16'(state_kill), 16'd0);
      chk("async cause", 16'(viol_cause), 16'd0);
      chk("async cnt", 16'(viol_cnt), 16'd0);
      chk("async cnt2", 16'(viol_cnt2), 16'd0);
      reset_n = 1'b1;
      #1;
      chk("async post reset", 16'(reset), 16'd0);
      cyc();
      #3;
      chk("async run kill", 16'(state_kill), 16'd0);
      chk("async run cnt", 16'(viol_cnt), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
